axis_rr_arbiter: RTL and testbench
==================================

# axis_rr_arbiter

- Packet-level round-robin arbiter merging NUM_SLAVE_STREAMS AXI-Stream inputs onto one output.
- Counterpart to the tdest-based stream switch; sits at a shared sink such as a MAC transmit path or a DMA write channel.
- Grants one input at a time and holds the grant until that input's tlast beat is accepted.
- Output is registered through a full-throughput skid buffer, so no combinational path exists from axis_o_tready to any axis_i_tready.

## Interface
- AXIS_BYTES, 1: data width in bytes.
- NUM_SLAVE_STREAMS, 4: number of inputs; legal range 1..16.
- IDX_BITS, derived: max(1, $clog2(NUM_SLAVE_STREAMS)); not overridable.
- clk  in  1  single clock; all logic on the rising edge.
- sresetn  in  1  reset, asynchronous, active-low; deassertion synchronised externally.
- axis_i_tready  out  NUM_SLAVE_STREAMS  per-input ready.
- axis_i_tvalid  in  NUM_SLAVE_STREAMS  per-input valid.
- axis_i_tlast  in  NUM_SLAVE_STREAMS  per-input last.
- axis_i_tdata  in  NUM_SLAVE_STREAMS*AXIS_BYTES*8  input i occupies bits [i*AXIS_BYTES*8 +: AXIS_BYTES*8].
- axis_o_tready  in  1  output ready.
- axis_o_tvalid  out  1  output valid.
- axis_o_tlast  out  1  output last.
- axis_o_tdata  out  AXIS_BYTES*8  output data.
- axis_o_tdest  out  IDX_BITS  source index of the current beat; present only with AXIS_ARB_TDEST_EN.

## Operation
- The FSM has two states: IDLE and LOCKED. Registers: grant[IDX_BITS-1:0] and last_grant[IDX_BITS-1:0].
- IDLE:
  - Every axis_i_tready is 0.
  - If any axis_i_tvalid is set, select the first set bit searching from last_grant+1 upward, wrapping modulo NUM_SLAVE_STREAMS.
  - Load the selection into grant and go to LOCKED next cycle.
  - If no tvalid is set, stay in IDLE.
- LOCKED:
  - axis_i_tready[grant] = skid-buffer input ready. All other tready are 0.
  - The skid buffer takes tvalid, tlast and tdata from the granted input.
  - When a beat with tlast=1 is accepted from input grant, set last_grant ← grant and go to IDLE.
- Packets are never interleaved. A granted input that drops tvalid mid-packet keeps the grant indefinitely; there is no timeout.
- Requests arriving on other inputs during LOCKED are only considered at the next IDLE.
- NUM_SLAVE_STREAMS=1: the round-robin search degenerates to index 0. IDLE/LOCKED sequencing is unchanged.
- Skid buffer:
  - 2-entry buffer. Input ready is registered and equals "not full".
  - Sustains 1 beat/cycle under continuous axis_o_tready.
  - Holds tdata/tlast/tdest stable while axis_o_tvalid=1 and axis_o_tready=0.

## Timing
- Reset values: state=IDLE, last_grant=NUM_SLAVE_STREAMS-1 (input 0 has first priority), grant=0, skid buffer empty. All axis_i_tready=0, axis_o_tvalid=0, axis_o_tlast=0, axis_o_tdata=0, axis_o_tdest=0.
- Arbitration bubble: one cycle per packet.
  - Input tvalid seen in IDLE at cycle n → LOCKED at n+1 → first beat can be accepted at n+1.
  - After a tlast acceptance at cycle m, the FSM is in IDLE at m+1, the next grant takes effect at m+2, and the next first beat can be accepted at m+2.
- Latency: a beat accepted from an input at cycle n appears on axis_o_* at cycle n+1 if the buffer was empty.
- Throughput: a single packet of L beats occupies L+1 cycles of arbiter time.
- Reset asserted mid-packet: all state clears immediately and any buffered beats are dropped. Downstream may therefore see a packet without tlast; the sink must tolerate this after reset.
- A tlast acceptance and a new request in the same cycle: the new request is not granted until the next IDLE cycle.

## Configuration
- AXIS_ARB_TDEST_EN defined:
  - The axis_o_tdest port exists.
  - The skid buffer carries grant alongside each beat, so tdest is aligned with the corresponding tdata.
- Not defined:
  - The port is absent and no tdest storage is built.
  - All other behaviour is identical.

## Structure
- Package axis_arb_pkg holds:
  - typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;
  - function rr_next(req, last) returning the round-robin index, so other arbiters can reuse it.
- Sub-module axis_skid_buffer: width parameter WIDTH, carrying {tdest?, tlast, tdata}. Same clk/sresetn as the arbiter.

## Test plan
- Reset then single packet:
  - Stimulus: input 2 sends 3 beats 0xA0,0xA1,0xA2 (tlast on 0xA2), axis_o_tready=1.
  - Response: output beats appear starting 2 cycles after the first tvalid, in order, with tlast only on 0xA2 and tdest=2.
- Fairness:
  - Stimulus: inputs 0, 1, 3 all continuously hold 1-beat packets.
  - Response: grant order is 0,1,3,0,1,3; each packet is followed by a 1-cycle bubble.
- No interleave:
  - Stimulus: input 0 sends a 4-beat packet with tvalid deasserted for 5 cycles after beat 2, while input 1 requests throughout.
  - Response: all 4 beats from input 0 are contiguous on the output, and input 1's packet follows.
- Backpressure:
  - Stimulus: axis_o_tready toggles 1,0,1,0 during a 6-beat packet.
  - Response: all 6 beats are delivered, none lost or duplicated, and the output holds stable while stalled. axis_i_tready drops once 2 beats are buffered.
- Mid-packet reset:
  - Stimulus: assert sresetn=0 for 1 cycle after beat 2 of 5.
  - Response: axis_o_tvalid=0 and all axis_i_tready=0 in that cycle. The next grant goes to input 0 if it is requesting.
- NUM_SLAVE_STREAMS=1:
  - Stimulus: back-to-back 2-beat packets.
  - Response: correct data, with one bubble cycle between packets.

Source files
------------

// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the AXI-Stream round-robin arbiter.
// rr_next is reusable by any arbiter with up to 16 requesters.
package axis_arb_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_t;

  localparam int RR_MAX = 16;

  // First set bit of req searching from last+1 upward, wrapping.
  // Unused request bits must be zero, so wrapping modulo 16 is
  // equivalent to wrapping modulo the real requester count.
  function automatic logic [3:0] rr_next(
    input logic [RR_MAX-1:0] req,
    input logic [3:0]        last
  );
    logic [3:0] sel;
    logic [3:0] idx;
    logic       found;
    sel   = '0;
    found = 1'b0;
    for (int i = 1; i <= RR_MAX; i++) begin
      idx = last + 4'(i);
      if (!found && req[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-Stream skid buffer, full throughput.
// Input ready comes straight from a flop (not full).
module axis_skid_buffer #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             sresetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic [WIDTH-1:0] skid_data;
  logic             skid_valid;
  logic             in_fire;
  logic             out_load;

  assign in_ready = ~skid_valid;
  assign in_fire  = in_valid & in_ready;
  assign out_load = ~out_valid | out_ready;

  // Output register refills from skid first; skid catches a beat on stall.
  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (out_load) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_data   <= skid_data;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= in_fire;
        if (in_fire) out_data <= in_data;
      end
    end else if (in_fire) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
    end
  end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-level round-robin AXI-Stream arbiter with registered output.
// Define AXIS_ARB_TDEST_EN to add axis_o_tdest (source index per beat).
module axis_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter  int AXIS_BYTES        = 1,
  parameter  int NUM_SLAVE_STREAMS = 4,
  localparam int IDX_BITS =
    (NUM_SLAVE_STREAMS > 1) ? $clog2(NUM_SLAVE_STREAMS) : 1
) (
  input  logic                                    clk,
  input  logic                                    sresetn,
  output logic [NUM_SLAVE_STREAMS-1:0]            axis_i_tready,
  input  logic [NUM_SLAVE_STREAMS-1:0]            axis_i_tvalid,
  input  logic [NUM_SLAVE_STREAMS-1:0]            axis_i_tlast,
  input  logic [NUM_SLAVE_STREAMS*AXIS_BYTES*8-1:0] axis_i_tdata,
  input  logic                                    axis_o_tready,
  output logic                                    axis_o_tvalid,
  output logic                                    axis_o_tlast,
  output logic [AXIS_BYTES*8-1:0]                 axis_o_tdata
`ifdef AXIS_ARB_TDEST_EN
  ,
  output logic [IDX_BITS-1:0]                     axis_o_tdest
`endif
);

  localparam int DW = AXIS_BYTES * 8;
`ifdef AXIS_ARB_TDEST_EN
  localparam int SBW = IDX_BITS + 1 + DW;
`else
  localparam int SBW = 1 + DW;
`endif

  arb_state_t          state;
  arb_state_t          state_d;
  logic [IDX_BITS-1:0] grant;
  logic [IDX_BITS-1:0] grant_d;
  logic [IDX_BITS-1:0] last_grant;
  logic [IDX_BITS-1:0] last_grant_d;

  logic                sel_valid;
  logic                sel_last;
  logic [DW-1:0]       sel_data;

  logic                sb_valid;
  logic                sb_ready;
  logic [SBW-1:0]      sb_in;
  logic [SBW-1:0]      sb_out;

  // Route the granted input's beat toward the skid buffer.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_SLAVE_STREAMS; i++) begin
      if (grant == IDX_BITS'(i)) begin
        sel_valid = axis_i_tvalid[i];
        sel_last  = axis_i_tlast[i];
        sel_data  = axis_i_tdata[i*DW +: DW];
      end
    end
  end

  // Arbitrate in IDLE; in LOCKED pass beats until tlast is taken.
  always_comb begin
    state_d       = state;
    grant_d       = grant;
    last_grant_d  = last_grant;
    axis_i_tready = '0;
    sb_valid      = 1'b0;
    unique case (state)
      ARB_IDLE: begin
        if (|axis_i_tvalid) begin
          grant_d = IDX_BITS'(rr_next(16'(axis_i_tvalid),
                                      4'(last_grant)));
          state_d = ARB_LOCKED;
        end
      end
      ARB_LOCKED: begin
        sb_valid = sel_valid;
        for (int i = 0; i < NUM_SLAVE_STREAMS; i++) begin
          if (grant == IDX_BITS'(i)) axis_i_tready[i] = sb_ready;
        end
        if (sel_valid && sb_ready && sel_last) begin
          last_grant_d = grant;
          state_d      = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Arbiter state; input 0 gets first priority out of reset.
  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) begin
      state      <= ARB_IDLE;
      grant      <= '0;
      last_grant <= IDX_BITS'(NUM_SLAVE_STREAMS - 1);
    end else begin
      state      <= state_d;
      grant      <= grant_d;
      last_grant <= last_grant_d;
    end
  end

`ifdef AXIS_ARB_TDEST_EN
  assign sb_in = {grant, sel_last, sel_data};
  assign {axis_o_tdest, axis_o_tlast, axis_o_tdata} = sb_out;
`else
  assign sb_in = {sel_last, sel_data};
  assign {axis_o_tlast, axis_o_tdata} = sb_out;
`endif

  axis_skid_buffer #(
    .WIDTH(SBW)
  ) u_skid (
    .clk      (clk),
    .sresetn  (sresetn),
    .in_valid (sb_valid),
    .in_ready (sb_ready),
    .in_data  (sb_in),
    .out_valid(axis_o_tvalid),
    .out_ready(axis_o_tready),
    .out_data (sb_out)
  );

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed bench for axis_rr_arbiter: a 4-input and a 1-input instance.
// Per-input beat queues drive the inputs; a negedge monitor logs traffic.
module tb_axis_rr_arbiter;

  typedef struct packed {
    logic       gap;
    logic       last;
    logic [7:0] data;
  } beat_t;

  logic       clk = 1'b0;
  logic       sresetn;
  logic [4:0] pv;
  logic [4:0] pl;
  logic [7:0] pd [5];
  logic [4:0] pres_gap;
  logic [4:0] fire;

  logic [3:0]  i_ready;
  logic [31:0] i_data;
  logic        o_ready;
  logic        o_valid;
  logic        o_last;
  logic [7:0]  o_data;

  logic [0:0]  r1;
  logic        o_ready1;
  logic        ov1;
  logic        ol1;
  logic [7:0]  od1;
`ifdef AXIS_ARB_TDEST_EN
  logic [1:0]  o_dest;
  logic [0:0]  od1_dest;
`endif

  beat_t      sq [5][$];
  logic [8:0] out_q [$];
  int         out_cyc [$];
  logic [1:0] dest_q [$];
  int         acc_src [$];
  int         acc_cyc [$];
  int         acc1_cyc [$];
  logic [8:0] out1_q [$];

  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   t0;
  int   k;
  bit   tog;
  bit   hold_en;
  bit   prev_stall;
  logic [8:0] prev_beat;

  int   exp_src [6] = '{0, 1, 3, 0, 1, 3};
  int   exp_d2  [6] = '{'h110, 'h120, 'h130, 'h111, 'h121, 'h131};
  int   exp_d3  [6] = '{'h0B0, 'h0B1, 'h0B2, 'h1B3, 'h0C0, 'h1C1};
  int   exp_d6  [4] = '{'h040, 'h141, 'h050, 'h151};
  int   exp_c6  [4] = '{1, 2, 4, 5};

  always #5 clk = ~clk;

  assign i_data = {pd[3], pd[2], pd[1], pd[0]};

  axis_rr_arbiter #(
    .AXIS_BYTES       (1),
    .NUM_SLAVE_STREAMS(4)
  ) dut (
    .clk          (clk),
    .sresetn      (sresetn),
    .axis_i_tready(i_ready),
    .axis_i_tvalid(pv[3:0]),
    .axis_i_tlast (pl[3:0]),
    .axis_i_tdata (i_data),
    .axis_o_tready(o_ready),
    .axis_o_tvalid(o_valid),
    .axis_o_tlast (o_last),
    .axis_o_tdata (o_data)
`ifdef AXIS_ARB_TDEST_EN
    ,
    .axis_o_tdest (o_dest)
`endif
  );

  axis_rr_arbiter #(
    .AXIS_BYTES       (1),
    .NUM_SLAVE_STREAMS(1)
  ) dut1 (
    .clk          (clk),
    .sresetn      (sresetn),
    .axis_i_tready(r1),
    .axis_i_tvalid(pv[4:4]),
    .axis_i_tlast (pl[4:4]),
    .axis_i_tdata (pd[4]),
    .axis_o_tready(o_ready1),
    .axis_o_tvalid(ov1),
    .axis_o_tlast (ol1),
    .axis_o_tdata (od1)
`ifdef AXIS_ARB_TDEST_EN
    ,
    .axis_o_tdest (od1_dest)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      fire = pv & {r1, i_ready};
      for (int i = 0; i < 4; i++) begin
        if (fire[i]) begin
          acc_src.push_back(i);
          acc_cyc.push_back(cyc);
        end
      end
      if (fire[4]) acc1_cyc.push_back(cyc);
      if (o_valid && o_ready) begin
        out_q.push_back({o_last, o_data});
        out_cyc.push_back(cyc);
`ifdef AXIS_ARB_TDEST_EN
        dest_q.push_back(o_dest);
`endif
      end
      if (ov1 && o_ready1) out1_q.push_back({ol1, od1});
      if (hold_en && prev_stall)
        chk("hold", 32'({o_valid, o_last, o_data}),
            32'({1'b1, prev_beat}));
      prev_stall = o_valid && !o_ready;
      prev_beat  = {o_last, o_data};
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  task automatic present();
    beat_t b;
    for (int i = 0; i < 5; i++) begin
      if (sq[i].size() > 0) begin
        b           = sq[i][0];
        pv[i]       = !b.gap;
        pl[i]       = b.last & !b.gap;
        pd[i]       = b.data;
        pres_gap[i] = b.gap;
      end else begin
        pv[i]       = 1'b0;
        pl[i]       = 1'b0;
        pd[i]       = 8'h00;
        pres_gap[i] = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      if ((fire[i] || pres_gap[i]) && sq[i].size() > 0)
        void'(sq[i].pop_front());
    end
    present();
    if (tog) o_ready = !o_ready;
  endtask

  task automatic push(input int s, input logic g, input logic l,
                      input logic [7:0] d);
    beat_t b;
    b.gap  = g;
    b.last = l;
    b.data = d;
    sq[s].push_back(b);
  endtask

  task automatic pkt(input int s, input logic [7:0] base, input int n);
    for (int j = 0; j < n; j++)
      push(s, 1'b0, (j == n - 1), base + 8'(j));
  endtask

  task automatic clear();
    out_q.delete();
    out_cyc.delete();
    dest_q.delete();
    acc_src.delete();
    acc_cyc.delete();
    acc1_cyc.delete();
    out1_q.delete();
  endtask

  task automatic do_reset();
    sresetn = 1'b0;
    for (int i = 0; i < 5; i++) sq[i].delete();
    present();
    step();
    step();
    sresetn = 1'b1;
    step();
  endtask

  task automatic run_out(input int n, input int maxc, input string tag);
    int c;
    c = 0;
    while (out_q.size() < n && c < maxc) begin
      step();
      c++;
    end
    chk(tag, 32'(out_q.size()), 32'(n));
  endtask

  initial begin
    sresetn  = 1'b0;
    o_ready  = 1'b1;
    o_ready1 = 1'b1;
    tog      = 1'b0;
    hold_en  = 1'b0;
    fire     = '0;
    present();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ovalid", 32'(o_valid), 0);
    chk("rst_iready", 32'(i_ready), 0);
    chk("rst_olast", 32'(o_last), 0);
    chk("rst_odata", 32'(o_data), 0);
    chk("rst_ovalid1", 32'(ov1), 0);
`ifdef AXIS_ARB_TDEST_EN
    chk("rst_tdest", 32'(o_dest), 0);
`endif
    sresetn = 1'b1;
    step();

    // single packet from input 2
    clear();
    pkt(2, 8'hA0, 3);
    present();
    t0 = cyc;
    run_out(3, 20, "t1_count");
    chk("t1_b0", 32'(out_q[0]), 'h0A0);
    chk("t1_b1", 32'(out_q[1]), 'h0A1);
    chk("t1_b2", 32'(out_q[2]), 'h1A2);
    chk("t1_lat", 32'(out_cyc[0] - t0), 2);
`ifdef AXIS_ARB_TDEST_EN
    chk("t1_tdest", 32'(dest_q[0]), 2);
    chk("t1_tdest2", 32'(dest_q[2]), 2);
`endif
    repeat (2) step();
    chk("t1_idle_rdy", 32'(i_ready), 0);

    // fairness across inputs 0, 1, 3
    do_reset();
    clear();
    for (int j = 0; j < 2; j++) begin
      pkt(0, 8'h10 + 8'(j), 1);
      pkt(1, 8'h20 + 8'(j), 1);
      pkt(3, 8'h30 + 8'(j), 1);
    end
    present();
    t0 = cyc;
    run_out(6, 40, "t2_count");
    for (int j = 0; j < 6; j++) begin
      chk("t2_src", 32'(acc_src[j]), 32'(exp_src[j]));
      chk("t2_cyc", 32'(acc_cyc[j] - t0), 32'(1 + 2 * j));
      chk("t2_data", 32'(out_q[j]), 32'(exp_d2[j]));
    end

    // no interleave while input 0 stalls mid-packet
    clear();
    push(0, 1'b0, 1'b0, 8'hB0);
    push(0, 1'b0, 1'b0, 8'hB1);
    repeat (5) push(0, 1'b1, 1'b0, 8'h00);
    push(0, 1'b0, 1'b0, 8'hB2);
    push(0, 1'b0, 1'b1, 8'hB3);
    pkt(1, 8'hC0, 2);
    present();
    run_out(6, 60, "t3_count");
    for (int j = 0; j < 6; j++)
      chk("t3_data", 32'(out_q[j]), 32'(exp_d3[j]));

    // backpressure: full stall, then toggling ready
    clear();
    o_ready = 1'b0;
    hold_en = 1'b1;
    pkt(2, 8'hD0, 6);
    present();
    repeat (6) step();
    chk("t4_acc2", 32'(acc_src.size()), 2);
    chk("t4_irdy", 32'(i_ready), 0);
    chk("t4_ovalid", 32'(o_valid), 1);
    chk("t4_odata", 32'(o_data), 'hD0);
    tog = 1'b1;
    run_out(6, 60, "t4_count");
    tog     = 1'b0;
    o_ready = 1'b1;
    repeat (4) step();
    hold_en = 1'b0;
    chk("t4_nodup", 32'(out_q.size()), 6);
    for (int j = 0; j < 6; j++)
      chk("t4_data", 32'(out_q[j]),
          32'({(j == 5), 8'hD0 + 8'(j)}));

    // reset in the middle of a 5-beat packet
    clear();
    pkt(1, 8'hE0, 5);
    present();
    k = 0;
    while (acc_src.size() < 2 && k < 20) begin
      step();
      k++;
    end
    chk("t5_pre", 32'(acc_src.size()), 2);
    chk("t5_pre_ovalid", 32'(o_valid), 1);
    pkt(0, 8'hF0, 1);
    present();
    sresetn = 1'b0;
    #1;
    chk("t5_ovalid", 32'(o_valid), 0);
    chk("t5_irdy", 32'(i_ready), 0);
    clear();
    step();
    sresetn = 1'b1;
    k = 0;
    while (acc_src.size() < 1 && k < 20) begin
      step();
      k++;
    end
    chk("t5_src0", 32'(acc_src[0]), 0);
    run_out(1, 20, "t5_count");
    chk("t5_data", 32'(out_q[0]), 'h1F0);

    // single-input instance, back-to-back 2-beat packets
    do_reset();
    clear();
    pkt(4, 8'h40, 2);
    pkt(4, 8'h50, 2);
    present();
    t0 = cyc;
    k  = 0;
    while (out1_q.size() < 4 && k < 30) begin
      step();
      k++;
    end
    chk("t6_count", 32'(out1_q.size()), 4);
    for (int j = 0; j < 4; j++) begin
      chk("t6_data", 32'(out1_q[j]), 32'(exp_d6[j]));
      chk("t6_cyc", 32'(acc1_cyc[j] - t0), 32'(exp_c6[j]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
